in_reg_filter: RTL and testbench
================================

# in_reg_filter

Input-side capture register for the AP3 IO cell, the receive counterpart of the output register that drives the pad. Samples the pad input into the fabric clock domain through a synchronizer, rejects glitches with a programmable qualification counter, and reports filtered edges. A select line gives combinational bypass of the pad value for timing-critical inputs.

## Interface

- `SYNC_STAGES`, default 2: synchronizer depth, legal values 2..3.
- `FILT_W`, default 4: width of the filter length and the qualification counter.
- `RST_VAL`, default 1'b0: reset value of the synchronizer flops and the filtered value.

Ports:

- `clk`  in  1: fabric clock, rising edge; marked clock / clkbuf sink.
- `rst`  in  1: reset, synchronous, active-low; sampled on `clk` rising edge.
- `dataIn`  in  1: raw pad input, asynchronous to `clk`.
- `sel`  in  1: 1 = bypass, `dataOut` = `dataIn`; 0 = filtered path.
- `filt_len`  in  FILT_W: required count of consecutive mismatching cycles before a change is accepted.
- `dataOut`  out  1: selected output, `sel ? dataIn : filt_q`.
- `rise`  out  1: one-cycle pulse when `filt_q` goes 0 to 1.
- `fall`  out  1: one-cycle pulse when `filt_q` goes 1 to 0.
- `busy`  out  1: high while a candidate change is qualifying.

## Operation

- Synchronizer: shift chain `s[0..SYNC_STAGES-1]`, `s[0]` <= `dataIn`; `s_out` = last stage.
- Filter FSM:
  - STABLE: `cnt` = 0.
    - `s_out != filt_q` and `filt_len == 0`: accept immediately.
    - `s_out != filt_q` and `filt_len > 0`: `cnt` <= 1, go to QUALIFY.
  - QUALIFY:
    - `s_out == filt_q`: `cnt` <= 0, go to STABLE. The glitch is rejected and no pulse is produced.
    - `s_out != filt_q` and `cnt >= filt_len`: accept.
    - Otherwise: `cnt` <= `cnt + 1`.
- Accept: `filt_q` <= `s_out`, `cnt` <= 0, state <= STABLE, and the matching `rise`/`fall` pulses in the same cycle as the new `filt_q`.
- `filt_len` is read live every cycle. Lowering it mid-qualification below the current `cnt` causes acceptance on the next edge. The counter never wraps because acceptance occurs at `cnt == filt_len` ≤ 2^FILT_W-1.
- `busy` = (state == QUALIFY).
- `sel` affects only the `dataOut` mux. The synchronizer, filter, `rise` and `fall` run regardless of `sel`. Toggling `sel` causes no state change.
- Reset (`rst == 0` at an edge), applied from any state including mid-qualification:
  - synchronizer flops and `filt_q` <= `RST_VAL`;
  - `cnt` <= 0, state <= STABLE;
  - `rise` = `fall` = 0.
  - While reset is held, `dataOut` = `RST_VAL` when `sel` = 0, and `dataIn` when `sel` = 1.

## Timing

- Clean edge on `dataIn`, setup met before edge E0: `s_out` changes after edge E0+SYNC_STAGES-1. `filt_q` and the pulse appear after edge E0+SYNC_STAGES+`filt_len`.
- Default latency with `filt_len` = 0: 2 edges after capture, i.e. a 3-edge total from E0 inclusive.
- Glitch at `s_out` lasting W cycles: rejected iff W ≤ `filt_len`.
- `rise`/`fall` are registered and never both high. No back-to-back pulses are possible when `filt_len` > 0. With `filt_len` = 0, pulses may occur on consecutive cycles.
- Bypass path is purely combinational from `dataIn` to `dataOut`.
- Setup/clock-to-q annotations match the output register: 1e-10 on registered ports relative to `clk`.

## Structure

- Shared package `in_reg_pkg`:
  - state enum `filt_state_t` {STABLE, QUALIFY};
  - default constants `IN_REG_SYNC_STAGES` = 2 and `IN_REG_FILT_W` = 4.
- Sub-module `in_reg_sync`: parameterised synchronizer chain carrying the reset value, with `clk`/`rst` as in the parent. It is reusable for other AP3 IO inputs.
- Top level holds the FSM, counter, edge pulses and bypass mux.

## Test plan

- Reset with `RST_VAL` = 0 and `sel` = 0, then release. Hold `dataIn` = 0 → `dataOut` = 0, `rise`/`fall` = 0, `busy` = 0 throughout.
- Set `filt_len` = 0 and `dataIn` 0→1 before edge E0 → `dataOut` = 1 and `rise` = 1 for exactly one cycle after edge E0+2; no `fall`.
- Set `filt_len` = 3 and drive a 3-cycle high pulse on `dataIn` → `busy` high for 3 cycles, `dataOut` stays 0, no pulses. A 4-cycle high pulse → `dataOut` = 1 after edge E0+5 with one `rise`, then 0 later with one `fall`.
- Set `filt_len` = 7, hold `dataIn` = 1, and write `filt_len` = 2 when `cnt` = 5 → accept on the next edge with a single `rise`.
- Assert `rst` low during QUALIFY with `cnt` = 2 → on the next edge `cnt` = 0, `busy` = 0, `dataOut` = `RST_VAL`, and no pulse.
- With `sel` = 1, toggle `dataIn` every cycle → `dataOut` follows `dataIn` combinationally. Filter outputs follow the filtered rules independently, and switching `sel` back to 0 shows `filt_q` with no glitch pulses.

Source files
------------

// File: rtl/in_reg_pkg.sv
// Shared definitions for the AP3 IO input capture path.
package in_reg_pkg;

  // Filter state: STABLE = filtered value settled, QUALIFY = candidate change being counted
  typedef enum logic {
    STABLE  = 1'b0,
    QUALIFY = 1'b1
  } filt_state_t;

  localparam int IN_REG_SYNC_STAGES = 2;
  localparam int IN_REG_FILT_W      = 4;

endpackage

// File: rtl/in_reg_sync.sv
// Reset-valued synchronizer chain for a raw pad input; reusable for any AP3 IO input.
module in_reg_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] s;

  // Shift the asynchronous input through the chain; stage 0 is the capture flop
  always_ff @(posedge clk) begin
    if (!rst) begin
      s <= {STAGES{RST_VAL}};
    end else begin
      s <= {s[STAGES-2:0], d};
    end
  end

  assign q = s[STAGES-1];

endmodule

// File: rtl/in_reg_filter.sv
// Input capture register: synchronizer, glitch qualification filter, edge pulses and bypass mux.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   STABLE  | filt_q matches the synchronized input, cnt held at 0
//   QUALIFY | synchronized input differs from filt_q, cnt counts mismatches
module in_reg_filter
  import in_reg_pkg::*;
#(
  parameter int   SYNC_STAGES = IN_REG_SYNC_STAGES,
  parameter int   FILT_W      = IN_REG_FILT_W,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dataIn,
  input  logic              sel,
  input  logic [FILT_W-1:0] filt_len,
  output logic              dataOut,
  output logic              rise,
  output logic              fall,
  output logic              busy
);

  localparam logic [FILT_W-1:0] CNT_ONE = FILT_W'(1);

  logic              s_out;
  logic              filt_q;
  logic [FILT_W-1:0] cnt;
  filt_state_t       state;

  in_reg_sync #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (RST_VAL)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (dataIn),
    .q   (s_out)
  );

  // Qualify changes of the synchronized input; filt_len is read live, so lowering it
  // below the running count makes the next mismatching edge accept the change.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= STABLE;
      cnt    <= '0;
      filt_q <= RST_VAL;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        STABLE: begin
          if (s_out != filt_q) begin
            if (filt_len == '0) begin
              filt_q <= s_out;
              cnt    <= '0;
              rise   <= s_out;
              fall   <= !s_out;
            end else begin
              cnt   <= CNT_ONE;
              state <= QUALIFY;
            end
          end
        end
        QUALIFY: begin
          if (s_out == filt_q) begin
            cnt   <= '0;
            state <= STABLE;
          end else if (cnt >= filt_len) begin
            filt_q <= s_out;
            cnt    <= '0;
            state  <= STABLE;
            rise   <= s_out;
            fall   <= !s_out;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          cnt   <= '0;
          state <= STABLE;
        end
      endcase
    end
  end

  assign busy = (state == QUALIFY);

  // Bypass is purely combinational so timing-critical inputs skip the synchronizer
  assign dataOut = sel ? dataIn : filt_q;

endmodule

// File: tb/tb_in_reg_filter.sv
// Directed bench for in_reg_filter with a pulse scoreboard checked every cycle.
module tb_in_reg_filter;

  logic       clk = 1'b0;
  logic       rst;
  logic       dataIn;
  logic       sel;
  logic [3:0] filt_len;
  logic       dataOut;
  logic       rise;
  logic       fall;
  logic       busy;

  int cyc      = 0;
  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    bit is_rise;
    int at;
  } ev_t;
  ev_t sb[$];

  in_reg_filter #(
    .SYNC_STAGES (2),
    .FILT_W      (4),
    .RST_VAL     (1'b0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .dataIn   (dataIn),
    .sel      (sel),
    .filt_len (filt_len),
    .dataOut  (dataOut),
    .rise     (rise),
    .fall     (fall),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Input change driven now lands as filt_q/pulse lat edges later
  task automatic expect_pulse(input bit r, input int lat);
    ev_t e;
    e.is_rise = r;
    e.at      = cyc + lat;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    logic er;
    logic ef;
    ev_t  e;
    er = 1'b0;
    ef = 1'b0;
    if (cyc > 0) begin
      if (sb.size() > 0 && sb[0].at == cyc) begin
        e  = sb.pop_front();
        er = e.is_rise;
        ef = !e.is_rise;
      end
      chk("rise_pulse", rise, er);
      chk("fall_pulse", fall, ef);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic v;
    rst      = 1'b0;
    sel      = 1'b0;
    dataIn   = 1'b0;
    filt_len = 4'd0;
    tick();
    tick();
    chk("rst_dataOut", dataOut, 1'b0);
    chk("rst_busy", busy, 1'b0);
    sel    = 1'b1;
    dataIn = 1'b1;
    #1 chk("rst_bypass", dataOut, 1'b1);
    sel = 1'b0;
    #1 chk("rst_sel0", dataOut, 1'b0);
    dataIn = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_dataOut", dataOut, 1'b0);
      chk("idle_busy", busy, 1'b0);
    end

    // filt_len = 0: clean rise then clean fall, 3 edges from E0 inclusive
    dataIn = 1'b1;
    expect_pulse(1'b1, 3);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("l0_rise_dataOut", dataOut, i >= 3);
      chk("l0_rise_busy", busy, 1'b0);
    end
    dataIn = 1'b0;
    expect_pulse(1'b0, 3);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("l0_fall_dataOut", dataOut, i < 3);
      chk("l0_fall_busy", busy, 1'b0);
    end

    // filt_len = 0: one-cycle input pulse gives back-to-back rise and fall
    dataIn = 1'b1;
    expect_pulse(1'b1, 3);
    tick();
    dataIn = 1'b0;
    expect_pulse(1'b0, 3);
    repeat (4) tick();
    chk("b2b_dataOut", dataOut, 1'b0);

    // filt_len = 3: 3-cycle glitch is rejected
    filt_len = 4'd3;
    dataIn   = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 3) dataIn = 1'b0;
      chk("g3_busy", busy, (i >= 3) && (i <= 5));
      chk("g3_dataOut", dataOut, 1'b0);
    end

    // filt_len = 3: 4-cycle pulse is accepted, then its trailing edge too
    dataIn = 1'b1;
    expect_pulse(1'b1, 6);
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 4) begin
        dataIn = 1'b0;
        expect_pulse(1'b0, 6);
      end
      chk("g4_busy", busy, ((i >= 3) && (i <= 5)) || ((i >= 7) && (i <= 9)));
      chk("g4_dataOut", dataOut, (i >= 6) && (i <= 9));
    end

    // filt_len = 7 lowered to 2 while cnt = 5: accept on the next edge
    filt_len = 4'd7;
    dataIn   = 1'b1;
    expect_pulse(1'b1, 8);
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 7) filt_len = 4'd2;
      chk("live_busy", busy, (i >= 3) && (i <= 7));
      chk("live_dataOut", dataOut, i >= 8);
    end

    // Reset while a fall qualifies with cnt = 2: no fall pulse, output to reset value
    filt_len = 4'd3;
    dataIn   = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("preq_busy", busy, i >= 3);
      chk("preq_dataOut", dataOut, 1'b1);
    end
    rst = 1'b0;
    tick();
    chk("midq_rst_busy", busy, 1'b0);
    chk("midq_rst_dataOut", dataOut, 1'b0);
    tick();
    chk("midq_hold_busy", busy, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_busy", busy, 1'b0);
      chk("post_rst_dataOut", dataOut, 1'b0);
    end

    // Bypass: dataOut follows dataIn combinationally while the filter keeps running
    filt_len = 4'd0;
    sel      = 1'b1;
    v        = 1'b0;
    for (int i = 0; i < 7; i++) begin
      v      = ~v;
      dataIn = v;
      expect_pulse(v, 3);
      #1 chk("bypass_follow", dataOut, v);
      tick();
    end
    repeat (4) tick();
    chk("bypass_hold", dataOut, 1'b1);
    sel = 1'b0;
    #1 chk("sel_back_dataOut", dataOut, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sel_back_stable", dataOut, 1'b1);
      chk("sel_back_busy", busy, 1'b0);
    end

    chk("sb_empty", sb.size() == 0, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
